// File: rtl/n64_pif_pkg.sv
// n64_pif_pkg: shared definitions for the banked PIF RAM.
//   clr_state_t : clear-engine state encoding (IDLE / CLEAR)
//   clog2()     : ceiling log2, used to size the lane-select field of the
//                 byte address
package n64_pif_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/n64_pif_ram_lane.sv
// n64_pif_ram_lane: one 8-bit lane of the banked PIF RAM.
//   Storage of 2^ADDR_W bytes with two write ports (B has priority over A on
//   the same address) plus a clear write that zero-fills one entry per cycle.
//   Two registered read ports; reads return old data unless the build
//   defines PIF_RAM_BYPASS_EN, in which case same-cycle write data is
//   forwarded (B before A).
// Ports:
//   clk, reset_n          clock, async active-low reset (read registers only)
//   rd_zero               force read data to zero (clear engine running)
//   we_a/waddr_a/wdata_a  write port A
//   we_b/waddr_b/wdata_b  write port B (wins over A)
//   clr_we/clr_addr       zero-fill write
//   raddr_a/raddr_b       read addresses
//   rd_a/rd_b             registered read data
module n64_pif_ram_lane #(
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd_zero,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] waddr_a,
  input  logic [7:0]        wdata_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] waddr_b,
  input  logic [7:0]        wdata_b,
  input  logic              clr_we,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [7:0]        rd_a,
  output logic [7:0]        rd_b
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [7:0] mem [DEPTH];
  logic [7:0] fwd_a;
  logic [7:0] fwd_b;

  // Port B is written after port A so it wins on a shared address.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else begin
      if (we_a) mem[waddr_a] <= wdata_a;
      if (we_b) mem[waddr_b] <= wdata_b;
    end
  end

`ifdef PIF_RAM_BYPASS_EN
  always_comb begin
    fwd_a = mem[raddr_a];
    if (we_a && (waddr_a == raddr_a)) fwd_a = wdata_a;
    if (we_b && (waddr_b == raddr_a)) fwd_a = wdata_b;
    fwd_b = mem[raddr_b];
    if (we_a && (waddr_a == raddr_b)) fwd_b = wdata_a;
    if (we_b && (waddr_b == raddr_b)) fwd_b = wdata_b;
  end
`else
  always_comb begin
    fwd_a = mem[raddr_a];
    fwd_b = mem[raddr_b];
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_a <= '0;
      rd_b <= '0;
    end else begin
      rd_a <= rd_zero ? '0 : fwd_a;
      rd_b <= rd_zero ? '0 : fwd_b;
    end
  end

endmodule

// File: rtl/n64_pif_ram_banked.sv
// n64_pif_ram_banked: dual-port PIF RAM built from LANES byte lanes.
//   Port A is a byte port (byte address, byte data, read-valid strobe),
//   port B is a word port with per-lane write enables. A clear engine
//   zero-fills the array after reset and on a clear pulse; while it runs
//   (busy=1) port writes are dropped and reads return 0.
//   Optional build macro: PIF_RAM_BYPASS_EN (same-cycle write forwarding).
// Parameters: ADDR_W (word address width), LANES (bytes/word, 2..8, pow2),
//   RD_LAT (read latency, 1 or 2).
// Ports:
//   clk, reset_n                        clock, async active-low reset
//   address_a, wren_a, data_a, oe       byte port inputs
//   q_a, valid                          byte read data, read-valid
//   address_b, wren_b, be_b, data_b     word port inputs
//   q_b                                 word read data
//   clear                               zero-fill request pulse
//   busy                                clear engine running
module n64_pif_ram_banked
  import n64_pif_pkg::*;
#(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned LANES  = 4,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [ADDR_W+clog2(LANES)-1:0]    address_a,
  input  logic                              wren_a,
  input  logic [7:0]                        data_a,
  input  logic                              oe,
  output logic [7:0]                        q_a,
  output logic                              valid,
  input  logic [ADDR_W-1:0]                 address_b,
  input  logic                              wren_b,
  input  logic [LANES-1:0]                  be_b,
  input  logic [8*LANES-1:0]                data_b,
  output logic [8*LANES-1:0]                q_b,
  input  logic                              clear,
  output logic                              busy
);

  localparam int unsigned LW = clog2(LANES);
  localparam int unsigned W  = 8 * LANES;

  // Clear engine
  clr_state_t        state, state_next;
  logic [ADDR_W-1:0] cnt, cnt_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    busy       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (clear) begin
          state_next = ST_CLEAR;
          cnt_next   = '0;
        end
      end
      ST_CLEAR: begin
        busy = 1'b1;
        if (cnt == '1) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = ST_CLEAR;
    endcase
  end

  // Lane array
  logic [LW-1:0]     lane_sel;
  logic [ADDR_W-1:0] word_a;
  logic [7:0]        rd_a [LANES];
  logic [W-1:0]      rd_b;

  assign lane_sel = address_a[LW-1:0];
  assign word_a   = address_a[LW +: ADDR_W];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    n64_pif_ram_lane #(
      .ADDR_W(ADDR_W)
    ) u_lane (
      .clk      (clk),
      .reset_n  (reset_n),
      .rd_zero  (busy),
      .we_a     (wren_a && !busy && (lane_sel == LW'(i))),
      .waddr_a  (word_a),
      .wdata_a  (data_a),
      .we_b     (wren_b && be_b[i] && !busy),
      .waddr_b  (address_b),
      .wdata_b  (data_b[8*i +: 8]),
      .clr_we   (busy),
      .clr_addr (cnt),
      .raddr_a  (word_a),
      .raddr_b  (address_b),
      .rd_a     (rd_a[i]),
      .rd_b     (rd_b[8*i +: 8])
    );
  end

  // First read stage: lane select and oe travel alongside the lane reads.
  logic [LW-1:0] lane_sel_s1;
  logic          oe_s1;
  logic [7:0]    byte_s1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane_sel_s1 <= '0;
      oe_s1       <= 1'b0;
    end else begin
      lane_sel_s1 <= lane_sel;
      oe_s1       <= oe;
    end
  end

  assign byte_s1 = rd_a[lane_sel_s1];

  if (RD_LAT == 2) begin : g_lat2
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        q_a   <= '0;
        q_b   <= '0;
        valid <= 1'b0;
      end else begin
        q_a   <= byte_s1;
        q_b   <= rd_b;
        valid <= oe_s1;
      end
    end
  end else begin : g_lat1
    always_comb begin
      q_a   = byte_s1;
      q_b   = rd_b;
      valid = oe_s1;
    end
  end

endmodule

// File: tb/tb_n64_pif_ram_banked.sv
// Self-checking bench for n64_pif_ram_banked: one instance with RD_LAT=1 and
// one with RD_LAT=2 share the inputs and are checked against a byte-array
// reference model.
module tb_n64_pif_ram_banked;

  localparam int ADDR_W = 9;
  localparam int LANES  = 4;
  localparam int DEPTH  = 512;
  localparam int BYTES  = DEPTH * LANES;
`ifdef PIF_RAM_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] address_a = '0;
  logic        wren_a = 1'b0;
  logic [7:0]  data_a = '0;
  logic        oe = 1'b0;
  logic [8:0]  address_b = '0;
  logic        wren_b = 1'b0;
  logic [3:0]  be_b = '0;
  logic [31:0] data_b = '0;
  logic        clear = 1'b0;

  logic [7:0]  q_a1, q_a2;
  logic        valid1, valid2, busy1, busy2;
  logic [31:0] q_b1, q_b2;

  always #5 clk = ~clk;

  n64_pif_ram_banked #(.ADDR_W(ADDR_W), .LANES(LANES), .RD_LAT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .address_a(address_a), .wren_a(wren_a),
    .data_a(data_a), .oe(oe), .q_a(q_a1), .valid(valid1),
    .address_b(address_b), .wren_b(wren_b), .be_b(be_b), .data_b(data_b),
    .q_b(q_b1), .clear(clear), .busy(busy1));

  n64_pif_ram_banked #(.ADDR_W(ADDR_W), .LANES(LANES), .RD_LAT(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .address_a(address_a), .wren_a(wren_a),
    .data_a(data_a), .oe(oe), .q_a(q_a2), .valid(valid2),
    .address_b(address_b), .wren_b(wren_b), .be_b(be_b), .data_b(data_b),
    .q_b(q_b2), .clear(clear), .busy(busy2));

  int checks = 0;
  int errors = 0;

  // Reference model: flat byte array, remaining clear cycles, and the
  // expected outputs one and two cycles after sampling.
  logic [7:0]  rmem [BYTES];
  int          clr_left = DEPTH;
  logic [7:0]  e1_qa = '0, e2_qa = '0;
  logic        e1_v = 1'b0, e2_v = 1'b0;
  logic [31:0] e1_qb = '0, e2_qb = '0;
  logic        exp_busy = 1'b1;
  logic [41:0] exp1, exp2, act1, act2;

  assign act1 = {q_a1, valid1, q_b1, busy1};
  assign act2 = {q_a2, valid2, q_b2, busy2};

  function automatic logic [31:0] model_word(input int w);
    logic [31:0] r;
    for (int l = 0; l < LANES; l++) r[8*l +: 8] = rmem[w*LANES + l];
    return r;
  endfunction

  task automatic model_read(input bit bz, output logic [7:0] ra, output logic [31:0] rb);
    ra = bz ? 8'h00 : rmem[int'(address_a)];
    rb = bz ? 32'h0 : model_word(int'(address_b));
  endtask

  // Advance one clock: update the model from the current inputs, then
  // return 1 time unit after the rising edge.
  task automatic step();
    logic [7:0]  ra;
    logic [31:0] rb;
    bit          bz;
    if (!reset_n) begin
      clr_left = DEPTH;
      {e1_qa, e1_v, e1_qb, e2_qa, e2_v, e2_qb} = '0;
    end else begin
      bz = (clr_left > 0);
      if (!BYPASS) model_read(bz, ra, rb);
      if (!bz) begin
        if (wren_a) rmem[int'(address_a)] = data_a;
        if (wren_b)
          for (int l = 0; l < LANES; l++)
            if (be_b[l]) rmem[int'(address_b)*LANES + l] = data_b[8*l +: 8];
      end
      if (BYPASS) model_read(bz, ra, rb);
      if (bz) begin
        for (int l = 0; l < LANES; l++) rmem[(DEPTH - clr_left)*LANES + l] = 8'h00;
        clr_left--;
      end else if (clear) begin
        clr_left = DEPTH;
      end
      e2_qa = e1_qa; e2_v = e1_v; e2_qb = e1_qb;
      e1_qa = ra;    e1_v = oe;   e1_qb = rb;
    end
    exp_busy = (clr_left > 0);
    exp1 = {e1_qa, e1_v, e1_qb, exp_busy};
    exp2 = {e2_qa, e2_v, e2_qb, exp_busy};
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wren_a = 1'b0; wren_b = 1'b0; oe = 1'b0; clear = 1'b0; be_b = '0;
  endtask

  task automatic rand_inputs(input int word_span);
    address_a = 11'($urandom_range(word_span*LANES - 1));
    address_b = 9'($urandom_range(word_span - 1));
    wren_a    = 1'($urandom);
    data_a    = 8'($urandom);
    oe        = 1'($urandom);
    wren_b    = 1'($urandom);
    be_b      = 4'($urandom);
    data_b    = $urandom;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (act1 !== 42'h0_0000_0001) begin
        errors++;
        $display("FAIL reset_dut1 got %h exp %h", act1, 42'h0_0000_0001);
      end
      checks++;
      if (act2 !== 42'h0_0000_0001) begin
        errors++;
        $display("FAIL reset_dut2 got %h exp %h", act2, 42'h0_0000_0001);
      end
    end
  endtask

  task automatic test_init_clear();
    int busy_cycles;
    reset_n = 1'b1;
    #1;
    busy_cycles = busy1 ? 1 : 0;
    for (int c = 0; c < 700; c++) begin
      rand_inputs(DEPTH);
      step();
      checks++;
      if (act1 !== exp1) begin
        errors++;
        $display("FAIL init_clear_dut1 cyc %0d got %h exp %h", c, act1, exp1);
      end
      checks++;
      if (act2 !== exp2) begin
        errors++;
        $display("FAIL init_clear_dut2 cyc %0d got %h exp %h", c, act2, exp2);
      end
      if (busy1) busy_cycles++;
      if (!busy1 && !exp_busy) break;
    end
    idle_inputs();
    checks++;
    if (busy_cycles !== DEPTH) begin
      errors++;
      $display("FAIL init_clear_len got %0d exp %0d", busy_cycles, DEPTH);
    end
  endtask

  task automatic test_vectors();
    logic [31:0] want;
    // A writes 0xAB to byte 0x006, B reads word 1 two cycles later.
    idle_inputs();
    address_a = 11'h006; data_a = 8'hAB; wren_a = 1'b1;
    step();
    idle_inputs();
    step();
    address_b = 9'd1;
    step();
    checks++;
    if (q_b1 !== 32'h00AB0000 || q_b1 !== e1_qb) begin
      errors++;
      $display("FAIL vec_a_to_b got %h exp %h", q_b1, 32'h00AB0000);
    end
    step();
    checks++;
    if (q_b2 !== 32'h00AB0000) begin
      errors++;
      $display("FAIL vec_a_to_b_lat2 got %h exp %h", q_b2, 32'h00AB0000);
    end
    // Same word, same lane: B wins.
    wren_b = 1'b1; be_b = 4'hF; data_b = 32'h0;
    step();
    wren_b = 1'b1; be_b = 4'b0001; data_b = 32'hDEADBEEF;
    address_a = 11'h004; data_a = 8'h11; wren_a = 1'b1;
    step();
    idle_inputs();
    step();
    checks++;
    if (q_b1 !== 32'h000000EF || q_b1 !== e1_qb) begin
      errors++;
      $display("FAIL vec_b_wins got %h exp %h", q_b1, 32'h000000EF);
    end
    // Same word, different lanes: both land.
    wren_b = 1'b1; be_b = 4'b0001; data_b = 32'h00000033;
    address_a = 11'h007; data_a = 8'h22; wren_a = 1'b1;
    step();
    idle_inputs();
    step();
    checks++;
    if (q_b1 !== 32'h22000033) begin
      errors++;
      $display("FAIL vec_both_lanes got %h exp %h", q_b1, 32'h22000033);
    end
    // Read word 5 while writing it.
    address_b = 9'd5; wren_b = 1'b1; be_b = 4'hF; data_b = 32'hCAFEF00D;
    step();
    data_b = 32'h12345678;
    step();
    want = BYPASS ? 32'h12345678 : 32'hCAFEF00D;
    checks++;
    if (q_b1 !== want) begin
      errors++;
      $display("FAIL vec_same_cycle_read got %h exp %h", q_b1, want);
    end
    idle_inputs();
    step();
    checks++;
    if (q_b1 !== 32'h12345678) begin
      errors++;
      $display("FAIL vec_after_write got %h exp %h", q_b1, 32'h12345678);
    end
  endtask

  task automatic test_valid_latency();
    logic [6:0] obs1, obs2;
    idle_inputs();
    step();
    for (int c = 0; c < 7; c++) begin
      oe = (c < 3);
      step();
      obs1[c] = valid1;
      obs2[c] = valid2;
    end
    oe = 1'b0;
    checks++;
    if (obs1 !== 7'b0000111) begin
      errors++;
      $display("FAIL valid_lat1 got %b exp %b", obs1, 7'b0000111);
    end
    checks++;
    if (obs2 !== 7'b0001110) begin
      errors++;
      $display("FAIL valid_lat2 got %b exp %b", obs2, 7'b0001110);
    end
  endtask

  task automatic test_random(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      rand_inputs(8);
      step();
      checks++;
      if (act1 !== exp1) begin
        errors++;
        $display("FAIL random_dut1 cyc %0d got %h exp %h", c, act1, exp1);
      end
      checks++;
      if (act2 !== exp2) begin
        errors++;
        $display("FAIL random_dut2 cyc %0d got %h exp %h", c, act2, exp2);
      end
    end
    idle_inputs();
  endtask

  task automatic test_clear_reset();
    int busy_cycles;
    idle_inputs();
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int c = 1; c < 100; c++) begin
      rand_inputs(8);
      step();
      checks++;
      if (act1 !== exp1) begin
        errors++;
        $display("FAIL clear_run_dut1 cyc %0d got %h exp %h", c, act1, exp1);
      end
    end
    idle_inputs();
    reset_n = 1'b0;
    step();
    checks++;
    if (act2 !== 42'h0_0000_0001) begin
      errors++;
      $display("FAIL clear_midreset got %h exp %h", act2, 42'h0_0000_0001);
    end
    reset_n = 1'b1;
    #1;
    busy_cycles = busy1 ? 1 : 0;
    for (int c = 0; c < 700; c++) begin
      rand_inputs(8);
      clear = (c == 9);
      step();
      checks++;
      if (act1 !== exp1) begin
        errors++;
        $display("FAIL clear_restart_dut1 cyc %0d got %h exp %h", c, act1, exp1);
      end
      checks++;
      if (act2 !== exp2) begin
        errors++;
        $display("FAIL clear_restart_dut2 cyc %0d got %h exp %h", c, act2, exp2);
      end
      if (busy1) busy_cycles++;
      if (!busy1 && !exp_busy) break;
    end
    idle_inputs();
    checks++;
    if (busy_cycles !== DEPTH) begin
      errors++;
      $display("FAIL clear_restart_len got %0d exp %0d", busy_cycles, DEPTH);
    end
  endtask

  initial begin
    for (int i = 0; i < BYTES; i++) rmem[i] = 8'h00;
    test_reset();
    test_init_clear();
    test_vectors();
    test_valid_latency();
    test_random(400);
    test_clear_reset();
    test_random(150);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
